// File: rtl/reg_bank.sv
// 32-entry register file with two combinational read ports, one write port,
// hard-wired zero register and write-to-read bypass; reset loads the stack pointer.
module reg_bank #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [4:0]        WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam logic [4:0] SP_IDX = 5'd29;

   logic [DATA_W-1:0] regs [32];
   logic              wr_en;

   // Index 0 is never written, so it stays at its reset value of zero.
   assign wr_en = RegWrite && (WriteReg != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (5'(i) == SP_IDX) ? SP_RESET : '0;
         end
      end else if (wr_en) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Bypass lets a consumer in the same cycle see the value being written.
   always_comb begin
      ReadData1 = regs[ReadReg1];
      if (ReadReg1 == 5'd0) begin
         ReadData1 = '0;
      end else if (wr_en && (ReadReg1 == WriteReg)) begin
         ReadData1 = WriteData;
      end
   end

   always_comb begin
      ReadData2 = regs[ReadReg2];
      if (ReadReg2 == 5'd0) begin
         ReadData2 = '0;
      end else if (wr_en && (ReadReg2 == WriteReg)) begin
         ReadData2 = WriteData;
      end
   end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter SP_RESET, default 227, value loaded into register 29 (stack pointer) at reset.
REQ-003 Port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Port RegWrite, input, 1 bit: write enable for the current cycle.
REQ-006 Port WriteReg, input, 5 bits: destination register index, driven by the write-register select mux (rd = instr[15:11], rt, 31 or 29).
REQ-007 Port WriteData, input, DATA_W bits: data to be written.
REQ-008 Port ReadReg1, input, 5 bits: index for read port 1 (rs).
REQ-009 Port ReadReg2, input, 5 bits: index for read port 2 (rt).
REQ-010 Port ReadData1, output, DATA_W bits: contents of the register selected by ReadReg1.
REQ-011 Port ReadData2, output, DATA_W bits: contents of the register selected by ReadReg2.

Function
REQ-012 Storage SHALL be 32 registers of DATA_W bits, indices 0..31.
REQ-013 Write: on rising clk with reset=0 and RegWrite=1, register[WriteReg] SHALL take WriteData; the new value is visible in storage from the next cycle.
REQ-014 With RegWrite=0, no register SHALL change.
REQ-015 Register 0 SHALL read as 0 on both ports at all times; writes to index 0 SHALL be discarded.
REQ-016 Reads SHALL be combinational: ReadDataN follows ReadRegN and storage within the same cycle, with no clock latency.
REQ-017 Write bypass: when RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle, ReadDataN SHALL present WriteData (not the old stored value).
REQ-018 Both read ports SHALL operate independently; ReadReg1==ReadReg2 SHALL return identical data on both ports.
REQ-019 Indices 29 and 31 SHALL have no special write behaviour beyond reset; link (31) and stack (29) writes go through the normal write port.
REQ-020 No read or write index is out of range (5-bit index, 32 entries); no error signalling exists.

Reset
REQ-021 On rising clk with reset=1, all registers SHALL become 0 except register 29, which SHALL become SP_RESET.
REQ-022 reset SHALL take priority over a simultaneous write; the write in that cycle is lost.
REQ-023 The cycle after reset, ReadDataN SHALL show 0 for every index except 29, which shows SP_RESET (bypass still applies if RegWrite=1 in that cycle).
REQ-024 Before the first reset, register contents are undefined; the bench SHALL apply reset before checking.

Verification
REQ-025 Reset: reset=1 for 1 cycle, then read 29 and 5 -> ReadData1=227, ReadData2=0.
REQ-026 Write/read: write 0xDEADBEEF to 8, next cycle ReadReg1=8 -> ReadData1=0xDEADBEEF; RegWrite=0 with WriteData=0x1 to 8 -> 8 unchanged.
REQ-027 Zero register: write 0x12345678 to 0 with RegWrite=1 -> ReadData1 for index 0 reads 0 in the same cycle and after.
REQ-028 Bypass: RegWrite=1, WriteReg=31, WriteData=0x00400008, ReadReg2=31 in same cycle -> ReadData2=0x00400008 before the edge; ReadReg1=30 unaffected.
REQ-029 Reset vs write: reset=1 and RegWrite=1, WriteReg=29, WriteData=0x55 same cycle -> register 29 = 227 afterwards.
REQ-030 Full sweep: write index*3 to indices 1..31 on consecutive cycles, then read all pairs (i, 31-i) -> both ports return index*3 (0 for index 0).
